key_debounce: RTL and testbench



---
 rtl/fft_sa_pkg.sv | 24 ++
 rtl/key_debounce_chan.sv | 116 +++++++++++
 rtl/key_debounce.sv | 35 +++
 tb/tb_key_debounce.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_sa_pkg.sv
// Shared definitions for the spectrum analyzer front end: key channel map
// and the per-key debounce state encoding.
package fft_sa_pkg;

  localparam int KEY_NUM    = 5;
  localparam int KEY_VGA    = 0;
  localparam int KEY_FFT    = 1;
  localparam int KEY_RANGE  = 2;
  localparam int KEY_SPARE3 = 3;
  localparam int KEY_SPARE4 = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  // The key counts as held until a release has been fully accepted.
  function automatic logic state_is_pressed(input db_state_e s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchronizer, debounce FSM with stability counter,
// and registered level / press / release outputs.
module key_debounce_chan
  import fft_sa_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic press_async,
  output logic key_edge,
  output logic key_release,
  output logic key_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic      sync1_q, sync2_q;
  db_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic      level_q, level_d;
  logic      edge_q, edge_d;
  logic      release_q, release_d;

  // Input synchronizer; resets to the released level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= press_async;
      sync2_q <= sync1_q;
    end
  end

  // Next state: any change of the synchronized level restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses come from level transitions, so a rejected release bounce emits nothing.
  always_comb begin
    level_d   = state_is_pressed(state_q);
    edge_d    = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      edge_q    <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      edge_q    <= edge_d;
      release_q <= release_d;
    end
  end

  assign key_edge    = edge_q;
  assign key_release = release_q;
  assign key_level   = level_q;

endmodule

// File: rtl/key_debounce.sv
// Key conditioner top: normalizes pin polarity to 1 = pressed and runs one
// independent debounce channel per key.
module key_debounce
  import fft_sa_pkg::*;
#(
  parameter int NUM_KEYS        = KEY_NUM,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_edge,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_level
);

  logic [NUM_KEYS-1:0] press_raw_s;

  assign press_raw_s = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .press_async (press_raw_s[i]),
      .key_edge    (key_edge[i]),
      .key_release (key_release[i]),
      .key_level   (key_level[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length reference model checked every cycle,
// directed latency/bounce/reset scenarios, then random bounce trains.
module tb_key_debounce;

  localparam int NK = 5;
  localparam int N  = 16;
  localparam int AL = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_raw = 5'h1F;
  logic [NK-1:0] key_edge, key_release, key_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  key_debounce #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (N),
    .KEY_ACTIVE_LOW  (AL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_raw     (key_raw),
    .key_edge    (key_edge),
    .key_release (key_release),
    .key_level   (key_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a key's accepted level flips after N consecutive synchronized
  // samples that disagree with it; outputs show that level one cycle later.
  logic [NK-1:0] m_s1, m_s2, m_acc, m_level, m_edge, m_rel;
  int            m_run [NK];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_acc <= '0;
      m_level <= '0; m_edge <= '0; m_rel <= '0;
      for (int i = 0; i < NK; i++) m_run[i] <= 0;
    end else begin
      m_level <= m_acc;
      m_edge  <= m_acc & ~m_level;
      m_rel   <= ~m_acc & m_level;
      for (int i = 0; i < NK; i++) begin
        if (m_s2[i] != m_acc[i]) begin
          if (m_run[i] + 1 >= N) begin
            m_acc[i] <= ~m_acc[i];
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
      m_s2 <= m_s1;
      m_s1 <= (AL != 0) ? ~key_raw : key_raw;
    end
  end

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      total++;
      if ({key_edge, key_release, key_level} !== {m_edge, m_rel, m_level}) begin
        bad++;
        $display("FAIL outputs cyc=%0d got edge=%b rel=%b lvl=%b want edge=%b rel=%b lvl=%b",
                 cyc, key_edge, key_release, key_level, m_edge, m_rel, m_level);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Watch one key for ncyc cycles: first pulse cycle, pulse count, level then.
  task automatic watch(input int k, input bit rel, input int ncyc,
                       output int at, output int n, output int lvl);
    at = -1; n = 0; lvl = -1;
    repeat (ncyc) begin
      @(negedge clk);
      if (rel ? key_release[k] : key_edge[k]) begin
        n++;
        if (at < 0) begin
          at  = cyc;
          lvl = int'(key_level[k]);
        end
      end
    end
  endtask

  task automatic drive(input int k, input logic v, input int hold);
    @(posedge clk);
    #1 key_raw[k] = v;
    repeat (hold - 1) @(posedge clk);
  endtask

  initial begin
    int at, n, lvl, d, r;
    logic [NK-1:0] first_val;
    fork
      compare_loop();
    join_none

    reset   = 1'b1;
    key_raw = 5'h1F;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // All keys released: nothing for 100 cycles.
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if ((key_edge | key_release | key_level) != 5'd0) n++;
    end
    chk("idle_quiet", n, 0);

    // Clean press of key 1, then clean release.
    @(posedge clk); #1 key_raw[1] = 1'b0; d = cyc;
    watch(1, 1'b0, 60, at, n, lvl);
    chk("k1_edge_time", at, d + 19);
    chk("k1_edge_count", n, 1);
    chk("k1_edge_level", lvl, 1);
    @(posedge clk); #1 key_raw[1] = 1'b1; d = cyc;
    watch(1, 1'b1, 40, at, n, lvl);
    chk("k1_rel_time", at, d + 19);
    chk("k1_rel_level", lvl, 0);

    // Key 0 press bounce: lows of 5, 10, 15 separated by 3-cycle highs.
    fork
      begin
        drive(0, 1'b0, 5);  drive(0, 1'b1, 3);
        drive(0, 1'b0, 10); drive(0, 1'b1, 3);
        drive(0, 1'b0, 15); drive(0, 1'b1, 3);
        @(posedge clk); #1 key_raw[0] = 1'b0; d = cyc;
      end
      watch(0, 1'b0, 120, at, n, lvl);
    join
    chk("k0_bounce_time", at, d + 19);
    chk("k0_bounce_count", n, 1);
    drive(0, 1'b1, 40);

    // Keys 0 and 2 pressed together.
    @(posedge clk); #1 key_raw[0] = 1'b0; key_raw[2] = 1'b0; d = cyc;
    at = -1; first_val = '0;
    repeat (40) begin
      @(negedge clk);
      if (key_edge != 5'd0 && at < 0) begin
        at = cyc;
        first_val = key_edge;
      end
    end
    chk("k02_time", at, d + 19);
    chk("k02_vec", int'(first_val), 5);
    @(posedge clk); #1 key_raw[0] = 1'b1; key_raw[2] = 1'b1;
    repeat (40) @(posedge clk);

    // Key 3: accepted press, release with a 4-cycle re-press bounce.
    drive(3, 1'b0, 30);
    fork
      begin
        drive(3, 1'b1, 8);
        drive(3, 1'b0, 4);
        @(posedge clk); #1 key_raw[3] = 1'b1; d = cyc;
      end
      watch(3, 1'b1, 80, at, n, lvl);
    join
    chk("k3_rel_time", at, d + 19);
    chk("k3_rel_count", n, 1);
    chk("k3_rel_level", lvl, 0);

    // Key 4: reset hits mid PRESS_WAIT with the key still held.
    @(posedge clk); #1 key_raw[4] = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    n = 0;
    repeat (2) begin
      @(negedge clk);
      if ((key_edge | key_release | key_level) != 5'd0) n++;
    end
    chk("k4_quiet_in_reset", n, 0);
    @(posedge clk); #1 reset = 1'b0; r = cyc;
    watch(4, 1'b0, 40, at, n, lvl);
    chk("k4_edge_after_reset", at, r + 19);
    chk("k4_edge_count", n, 1);
    drive(4, 1'b1, 40);

    // Random bounce trains on all keys with occasional resets.
    repeat (150) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 2) == 0) key_raw[i] = ~key_raw[i];
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
      repeat ($urandom_range(0, 29)) @(posedge clk);
    end
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
